// File: rtl/row_loader_if.sv
// row_loader_if: FIFO pop side, row-register-file write side and frame control of row_loader.
// stallCnt is present only when ROW_LOADER_PERF_EN is defined.
interface row_loader_if #(
    parameter int DATA_W    = 64,
    parameter int ROW_WORDS = 4,
    parameter int CNT_W     = 8
);
    localparam int AW = $clog2(ROW_WORDS);
    logic              start;
    logic [CNT_W-1:0]  numRows;
    logic              fifoEmpty;
    logic [DATA_W-1:0] fifoRdata;
    logic              fifoRen;
    logic              writeEn;
    logic [AW-1:0]     writeAddr;
    logic [DATA_W-1:0] writeData;
    logic              fullRow;
    logic              busy;
    logic              done;
`ifdef ROW_LOADER_PERF_EN
    logic [15:0]       stallCnt;
    modport master (output start, numRows, fifoEmpty, fifoRdata,
                    input fifoRen, writeEn, writeAddr, writeData, fullRow, busy, done, stallCnt);
    modport slave (input start, numRows, fifoEmpty, fifoRdata,
                   output fifoRen, writeEn, writeAddr, writeData, fullRow, busy, done, stallCnt);
`else
    modport master (output start, numRows, fifoEmpty, fifoRdata,
                    input fifoRen, writeEn, writeAddr, writeData, fullRow, busy, done);
    modport slave (input start, numRows, fifoEmpty, fifoRdata,
                   output fifoRen, writeEn, writeAddr, writeData, fullRow, busy, done);
`endif
endinterface

// File: rtl/row_loader.sv
// row_loader: pops FIFO words into one register-file row at a time, pulses fullRow, then drains.
// ROW_LOADER_PERF_EN adds a saturating FIFO-stall counter (stallCnt).
module row_loader #(
    parameter int DATA_W       = 64,
    parameter int ROW_WORDS    = 4,
    parameter int CNT_W        = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input logic         clk,
    input logic         rst,
    row_loader_if.slave bus
);
    localparam int AW  = $clog2(ROW_WORDS);
    localparam int DCW = $clog2(DRAIN_CYCLES);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2, DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     word_q, word_d, waddr_q, waddr_d;
    logic [CNT_W-1:0]  row_q, row_d, num_q, num_d;
    logic [DCW-1:0]    drain_q, drain_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, full_q, busy_q, busy_d, done_q, done_d;
    logic              pop, accept, drain_end, frame_end;

    always_comb begin
        pop       = state_q == LOAD && !bus.fifoEmpty;
        accept    = state_q == IDLE && bus.start;
        drain_end = state_q == DRAIN && drain_q == DCW'(DRAIN_CYCLES - 1);
        frame_end = drain_end && row_q == num_q;
        state_d   = accept ? (bus.numRows == '0 ? IDLE : LOAD)
                  : pop && word_q == AW'(ROW_WORDS - 1) ? FULL
                  : state_q == FULL ? DRAIN
                  : drain_end ? (frame_end ? IDLE : LOAD)
                  : state_q;
        word_d    = accept ? '0 : pop ? word_q + 1'b1 : word_q;
        row_d     = accept ? '0 : state_q == FULL ? row_q + 1'b1 : row_q;
        num_d     = accept ? bus.numRows : num_q;
        drain_d   = state_q == DRAIN && !drain_end ? drain_q + 1'b1 : '0;
        waddr_d   = pop ? word_q : waddr_q;
        wdata_d   = pop ? bus.fifoRdata : wdata_q;
        busy_d    = accept ? bus.numRows != '0 : frame_end ? 1'b0 : busy_q;
        done_d    = (accept && bus.numRows == '0) || frame_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            row_q   <= '0;
            num_q   <= '0;
            drain_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            row_q   <= row_d;
            num_q   <= num_d;
            drain_q <= drain_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wen_q   <= pop;
            full_q  <= state_q == FULL;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.fifoRen   = pop;
    assign bus.writeEn   = wen_q;
    assign bus.writeAddr = waddr_q;
    assign bus.writeData = wdata_q;
    assign bus.fullRow   = full_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef ROW_LOADER_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb
        stall_d = accept ? '0 : state_q == LOAD && bus.fifoEmpty && stall_q != 16'hFFFF ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign bus.stallCnt = stall_q;
`endif
endmodule
